// File: rtl/hedios_tx_arbiter_if.sv
// rtl/hedios_tx_arbiter_if.sv - requester/TX-queue bundle for the Hedios TX arbiter
//
// Purpose: groups the requester side (req, req_command, req_data, req_ack)
// and the TX queue side (tx_full, tx_command, tx_data, tx_push_packet) plus
// the busy/grant_id status of hedios_tx_arbiter.
// Modports:
//   master - the arbiter: samples requests and tx_full, drives acks, TX
//            packet fields, push strobe and status.
//   slave  - the environment: drives requests and tx_full, observes the rest.
// Parameter REQ_COUNT must match the arbiter instance (1..8).

interface hedios_tx_arbiter_if #(
  parameter int REQ_COUNT = 4
);

  logic [REQ_COUNT-1:0]    req;
  logic [REQ_COUNT*8-1:0]  req_command;
  logic [REQ_COUNT*32-1:0] req_data;
  logic [REQ_COUNT-1:0]    req_ack;
  logic                    tx_full;
  logic [7:0]              tx_command;
  logic [31:0]             tx_data;
  logic                    tx_push_packet;
  logic                    busy;
  logic [2:0]              grant_id;

  modport master (
    input  req, req_command, req_data, tx_full,
    output req_ack, tx_command, tx_data, tx_push_packet, busy, grant_id
  );

  modport slave (
    output req, req_command, req_data, tx_full,
    input  req_ack, tx_command, tx_data, tx_push_packet, busy, grant_id
  );

endinterface

// File: rtl/hedios_tx_arbiter.sv
// rtl/hedios_tx_arbiter.sv - round-robin arbiter feeding the Hedios serial TX queue
//
// Purpose: picks one of REQ_COUNT requesters, latches its command/data and
// pushes it into the TX queue with a one-cycle push strobe and a matching
// one-cycle acknowledge back to the requester.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - hedios_tx_arbiter_if.master (requests, acks, TX packet, status)
// Optional feature: define HEDIOS_TX_ARB_PRIO0_EN to give requester 0 strict
// priority over a round-robin among the others.

module hedios_tx_arbiter #(
  parameter int REQ_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hedios_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LATCH_DONE = 2'd1,
    PUSH       = 2'd2,
    GAP        = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            tx_command_q, tx_command_d;
  logic [31:0]           tx_data_q, tx_data_d;
  logic                  tx_push_q, tx_push_d;
  logic [REQ_COUNT-1:0]  req_ack_q, req_ack_d;
  logic [2:0]            grant_id_q, grant_id_d;
  logic [2:0]            last_grant_q, last_grant_d;

  // Arbitration
  logic [7:0]  req_ext;
  logic [3:0]  idx;
  logic        rr_found;
  logic [2:0]  rr_winner;
  logic        prio0_win;
  logic [2:0]  winner;
  logic [7:0]  sel_command;
  logic [31:0] sel_data;

  always_comb begin
    req_ext                  = '0;
    req_ext[REQ_COUNT-1:0]   = bus.req;
    idx                      = '0;
    rr_found                 = 1'b0;
    rr_winner                = '0;
    // Scan starting one past the last latched requester; a single wrap
    // subtraction suffices because last_grant+1+i < 2*REQ_COUNT.
    for (int i = 0; i < REQ_COUNT; i++) begin
      idx = {1'b0, last_grant_q} + 4'd1 + 4'(i);
      if (idx >= 4'(REQ_COUNT)) begin
        idx = idx - 4'(REQ_COUNT);
      end
      if (!rr_found && req_ext[idx[2:0]]) begin
        rr_found  = 1'b1;
        rr_winner = idx[2:0];
      end
    end
`ifdef HEDIOS_TX_ARB_PRIO0_EN
    prio0_win = bus.req[0];
`else
    prio0_win = 1'b0;
`endif
    winner      = prio0_win ? 3'd0 : rr_winner;
    sel_command = bus.req_command[{winner, 3'b000} +: 8];
    sel_data    = bus.req_data[{winner, 5'b00000} +: 32];
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    tx_command_d = tx_command_q;
    tx_data_d    = tx_data_q;
    tx_push_d    = 1'b0;
    req_ack_d    = '0;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          tx_command_d = sel_command;
          tx_data_d    = sel_data;
          grant_id_d   = winner;
          // A strict-priority win by requester 0 leaves the rotation alone.
          if (!prio0_win) begin
            last_grant_d = winner;
          end
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (!bus.tx_full) begin
          tx_push_d = 1'b1;
          for (int k = 0; k < REQ_COUNT; k++) begin
            req_ack_d[k] = (grant_id_q == 3'(k));
          end
          state_d = GAP;
        end
      end
      GAP: begin
        // Push/ack strobes are visible during this cycle; the packet fields
        // are cleared as the arbiter returns to IDLE.
        tx_command_d = '0;
        tx_data_d    = '0;
        state_d      = IDLE;
      end
      default: begin
        tx_command_d = '0;
        tx_data_d    = '0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_command_q <= '0;
      tx_data_q    <= '0;
      tx_push_q    <= 1'b0;
      req_ack_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= 3'(REQ_COUNT - 1);
    end else begin
      state_q      <= state_d;
      tx_command_q <= tx_command_d;
      tx_data_q    <= tx_data_d;
      tx_push_q    <= tx_push_d;
      req_ack_q    <= req_ack_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.tx_command     = tx_command_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_push_packet = tx_push_q;
  assign bus.req_ack        = req_ack_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: doc/hedios_tx_arbiter.md
HEDIOS_TX_ARBITER -- requirements
Module: hedios_tx_arbiter

Interface
REQ-001 Parameter REQ_COUNT, default 4, legal 1..8: number of requesters sharing the Hedios serial TX queue.
REQ-002 Port clk  input  1  single clock; all logic rising-edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port req  input  REQ_COUNT  per-requester packet request, level.
REQ-005 Port req_command  input  REQ_COUNT*8  packed commands; requester k at bits [8k+7:8k].
REQ-006 Port req_data  input  REQ_COUNT*32  packed data; requester k at bits [32k+31:32k].
REQ-007 Port req_ack  output  REQ_COUNT  one-cycle acknowledge; packet consumed.
REQ-008 Port tx_full  input  1  TX queue full.
REQ-009 Port tx_command  output  8  command to TX queue.
REQ-010 Port tx_data  output  32  data to TX queue.
REQ-011 Port tx_push_packet  output  1  one-cycle push strobe.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port grant_id  output  3  index of the requester most recently latched.

Function
REQ-014 FSM states IDLE, LATCH_DONE, PUSH, GAP; encoding free.
REQ-015 IDLE: if any req bit is high, select a winner, latch its command/data into tx_command/tx_data, set grant_id, go to PUSH; otherwise stay.
REQ-016 Winner selection is round-robin: search starts at last_grant+1 mod REQ_COUNT, first asserted req wins.
REQ-017 last_grant updates only on latch; a single requester that stays asserted wins every arbitration.
REQ-018 PUSH: if tx_full low, assert tx_push_packet and req_ack[grant_id] in the same cycle, go to GAP; if tx_full high, hold with all strobes low.
REQ-019 GAP: one idle cycle for tx_full to settle, then IDLE.
REQ-020 Latency: req high while IDLE and tx_full low -> tx_push_packet high exactly 2 cycles later; max throughput one packet per 3 cycles.
REQ-021 Requester holds req, command and data stable until req_ack; req is sampled only in IDLE.
REQ-022 Deasserting req after latch does not cancel the transfer; the latched packet is still pushed and acked.
REQ-023 Requester re-raising req in the cycle after req_ack is treated as a new request.
REQ-024 tx_push_packet and req_ack are never high for more than one consecutive cycle; at most one req_ack bit is high at a time.
REQ-025 tx_command/tx_data hold their latched value through PUSH and GAP and are cleared to 0 on return to IDLE.
REQ-026 Unused LATCH_DONE state and any illegal state encoding return to IDLE on the next cycle.

Reset
REQ-027 rst_n low asynchronously forces IDLE; tx_command=0, tx_data=0, tx_push_packet=0, req_ack=0, busy=0, grant_id=0, last_grant=REQ_COUNT-1, so requester 0 wins first.
REQ-028 Reset asserted mid-PUSH discards the latched packet with no push and no ack; the requester keeps req high and is served after reset.

Configuration
REQ-029 Macro HEDIOS_TX_ARB_PRIO0_EN defined: requester 0 has strict priority, winning whenever req[0] is high in IDLE, with round-robin among the others; last_grant unchanged when requester 0 wins.
REQ-030 HEDIOS_TX_ARB_PRIO0_EN undefined: pure round-robin across all REQ_COUNT requesters per REQ-016.

Verification
REQ-031 After reset, req=4'b0001, command 0x03, data 0x0000_00AA -> push at cycle 2 with tx_command=0x03, tx_data=0xAA, req_ack=4'b0001 in the same cycle.
REQ-032 req=4'b1111 held, each requester re-raises after ack -> grant order 0,1,2,3,0; pushes spaced exactly 3 cycles.
REQ-033 tx_full high for 5 cycles during PUSH -> no push and no ack while full; push and ack occur the first cycle tx_full is low.
REQ-034 req[2] dropped the cycle after latch -> packet from requester 2 still pushed; req_ack[2] pulses once.
REQ-035 rst_n low during PUSH with req[1] held -> outputs zero immediately, no ack; after release requester 1 pushed 2 cycles later.
REQ-036 With HEDIOS_TX_ARB_PRIO0_EN, req=4'b1111 held -> requester 0 wins every arbitration; without the macro, the REQ-032 order is produced.
